// File: rtl/dpram_pipe_pkg.sv
// dpram_pipe_pkg: shared constants and byte-lane helpers for dpram_pipe
package dpram_pipe_pkg;
   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int MAX_W           = 256;

   function automatic int calc_nbe(input int data, input int byte_w);
      return data / byte_w;
   endfunction

   function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w, input logic [MAX_W-1:0] be, input int byte_w);
      logic [MAX_W-1:0] r;
      for (int i = 0; i < MAX_W; i++) r[i] = be[i / byte_w] ? new_w[i] : old_w[i];
      return r;
   endfunction

   function automatic logic [MAX_W-1:0] byte_parity(input logic [MAX_W-1:0] d, input int byte_w, input int nbe);
      logic [MAX_W-1:0] p;
      p = '0;
      for (int i = 0; i < MAX_W; i++) if (i / byte_w < nbe) p[i / byte_w] ^= d[i];
      return p;
   endfunction
endpackage

// File: rtl/dpram_pipe_port.sv
// dpram_pipe_port: per-port read pipeline (RD_LAT stages, VALID shift, RDW mux); PERR output when DPRAM_PIPE_PARITY_EN is defined
module dpram_pipe_port
   import dpram_pipe_pkg::*;
#(
   parameter int DATA     = 16,
   parameter int BYTE     = 8,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0,
`ifdef DPRAM_PIPE_PARITY_EN
   localparam int W = DATA + calc_nbe(DATA, BYTE)
`else
   localparam int W = DATA
`endif
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic                           en_i,
   input  logic                           wr_i,
   input  logic [W-1:0]                   old_i,
   input  logic [W-1:0]                   new_i,
   output logic [DATA-1:0]                data_o,
`ifdef DPRAM_PIPE_PARITY_EN
   output logic [calc_nbe(DATA, BYTE)-1:0] perr_o,
`endif
   output logic                           valid_o
);
   logic [W-1:0] s1_q, s1_d, last_w;
   logic         v1_q, last_v;

   // capture the accessed word on EN; write-first returns this port's merged word
   always_comb s1_d = en_i ? ((wr_i && RDW_MODE == RDW_WRITE_FIRST) ? new_i : old_i) : s1_q;

   // first output stage; word holds between accesses
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         s1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         v1_q <= en_i;
      end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [W-1:0] s2_q, s2_d;
         logic         v2_q;
         always_comb s2_d = v1_q ? s1_q : s2_q;
         // optional second output stage
         always_ff @(posedge clk_i or negedge rst_n_i)
            if (!rst_n_i) begin
               s2_q <= '0;
               v2_q <= 1'b0;
            end else begin
               s2_q <= s2_d;
               v2_q <= v1_q;
            end
         assign last_w = s2_q;
         assign last_v = v2_q;
      end else begin : g_lat1
         assign last_w = s1_q;
         assign last_v = v1_q;
      end
   endgenerate

   assign valid_o = last_v;
`ifdef DPRAM_PIPE_PARITY_EN
   localparam int NBE = calc_nbe(DATA, BYTE);
   assign data_o = last_w[DATA-1:0];
   assign perr_o = last_v ? (NBE'(byte_parity(MAX_W'(last_w[DATA-1:0]), BYTE, NBE)) ^ last_w[W-1:DATA]) : '0;
`else
   assign data_o = last_w;
`endif
endmodule

// File: rtl/dpram_pipe.sv
// dpram_pipe: dual-port byte-enable RAM with 1/2-cycle read latency and collision counting; DPRAM_PIPE_PARITY_EN adds per-byte parity and PERR ports
module dpram_pipe
   import dpram_pipe_pkg::*;
#(
   parameter int DATA     = 16,
   parameter int ADDR     = 5,
   parameter int BYTE     = 8,
   parameter int RD_LAT   = 1,
   parameter int RDW_MODE = 0,
   parameter int CNT_W    = 8
) (
   input  logic                            clK,
   input  logic                            rst_N,
   input  logic                            a_port_EN,
   input  logic                            a_port_WR,
   input  logic [calc_nbe(DATA, BYTE)-1:0] a_port_BE,
   input  logic [ADDR-1:0]                 a_port_ADDR,
   input  logic [DATA-1:0]                 a_port_data_IN,
   output logic [DATA-1:0]                 a_port_data_OUT,
   output logic                            a_port_VALID,
   input  logic                            b_port_EN,
   input  logic                            b_port_WR,
   input  logic [calc_nbe(DATA, BYTE)-1:0] b_port_BE,
   input  logic [ADDR-1:0]                 b_port_ADDR,
   input  logic [DATA-1:0]                 b_port_data_IN,
   output logic [DATA-1:0]                 b_port_data_OUT,
   output logic                            b_port_VALID,
`ifdef DPRAM_PIPE_PARITY_EN
   output logic [calc_nbe(DATA, BYTE)-1:0] a_port_PERR,
   output logic [calc_nbe(DATA, BYTE)-1:0] b_port_PERR,
`endif
   output logic                            coll_ERR,
   output logic [CNT_W-1:0]                coll_CNT
);
   localparam int NBE   = calc_nbe(DATA, BYTE);
   localparam int DEPTH = 2 ** ADDR;
`ifdef DPRAM_PIPE_PARITY_EN
   localparam int W = DATA + NBE;
`else
   localparam int W = DATA;
`endif

   generate
      if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
         $error("dpram_pipe: RD_LAT must be 1 or 2");
      end
      if (DATA % BYTE != 0) begin : g_bad_byte
         $error("dpram_pipe: DATA must be a multiple of BYTE");
      end
   endgenerate

   // merge enabled bytes (and their fresh parity) into an existing word
   function automatic logic [W-1:0] merge_word(input logic [W-1:0] old_w, input logic [DATA-1:0] d, input logic [NBE-1:0] be);
      logic [W-1:0] w;
      w = W'(byte_merge(MAX_W'(old_w), MAX_W'(d), MAX_W'(be), BYTE));
`ifdef DPRAM_PIPE_PARITY_EN
      w[W-1:DATA] = (old_w[W-1:DATA] & ~be) | (NBE'(byte_parity(MAX_W'(d), BYTE, NBE)) & be);
`endif
      return w;
   endfunction

   logic [W-1:0]     mem [DEPTH];
   logic [W-1:0]     a_old, b_old, a_new, b_new, b_wr_word;
   logic             coll, coll_hit, coll_err_q;
   logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;

   assign a_old     = mem[a_port_ADDR];
   assign b_old     = mem[b_port_ADDR];
   assign a_new     = merge_word(a_old, a_port_data_IN, a_port_BE);
   assign b_new     = merge_word(b_old, b_port_data_IN, b_port_BE);
   assign coll      = a_port_EN & a_port_WR & b_port_EN & b_port_WR & (a_port_ADDR == b_port_ADDR);
   assign coll_hit  = coll & |(a_port_BE & b_port_BE);
   // on a collision B's merge is overlaid with A's bytes so A wins shared lanes
   assign b_wr_word = coll ? merge_word(b_new, a_port_data_IN, a_port_BE) : b_new;

   // storage writes; a colliding A write is folded into the B write
   always_ff @(posedge clK) begin
      if (b_port_EN && b_port_WR) mem[b_port_ADDR] <= b_wr_word;
      if (a_port_EN && a_port_WR && !coll) mem[a_port_ADDR] <= a_new;
   end

   always_comb coll_cnt_d = (coll_hit && coll_cnt_q != {CNT_W{1'b1}}) ? coll_cnt_q + 1'b1 : coll_cnt_q;

   // collision pulse and saturating counter
   always_ff @(posedge clK or negedge rst_N)
      if (!rst_N) begin
         coll_err_q <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         coll_err_q <= coll_hit;
         coll_cnt_q <= coll_cnt_d;
      end

   assign coll_ERR = coll_err_q;
   assign coll_CNT = coll_cnt_q;

   dpram_pipe_port #(.DATA(DATA), .BYTE(BYTE), .RD_LAT(RD_LAT), .RDW_MODE(RDW_MODE)) u_port_a (
      .clk_i   (clK),
      .rst_n_i (rst_N),
      .en_i    (a_port_EN),
      .wr_i    (a_port_WR),
      .old_i   (a_old),
      .new_i   (a_new),
      .data_o  (a_port_data_OUT),
`ifdef DPRAM_PIPE_PARITY_EN
      .perr_o  (a_port_PERR),
`endif
      .valid_o (a_port_VALID)
   );

   dpram_pipe_port #(.DATA(DATA), .BYTE(BYTE), .RD_LAT(RD_LAT), .RDW_MODE(RDW_MODE)) u_port_b (
      .clk_i   (clK),
      .rst_n_i (rst_N),
      .en_i    (b_port_EN),
      .wr_i    (b_port_WR),
      .old_i   (b_old),
      .new_i   (b_new),
      .data_o  (b_port_data_OUT),
`ifdef DPRAM_PIPE_PARITY_EN
      .perr_o  (b_port_PERR),
`endif
      .valid_o (b_port_VALID)
   );
endmodule

// File: tb/tb_dpram_pipe.sv
// tb_dpram_pipe: random + directed check of a read-first RD_LAT=1 and a write-first RD_LAT=2 instance against a word-level model
module tb_dpram_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_en, a_wr, b_en, b_wr;
   logic [1:0]  a_be, b_be;
   logic [4:0]  a_ad, b_ad;
   logic [15:0] a_di, b_di;
   logic [15:0] dq [2][2];
   logic        vq [2][2];
   logic        cerr [2];
   logic [7:0]  ccnt [2];

   always #5 clk = ~clk;

   dpram_pipe #(.RD_LAT(1), .RDW_MODE(0)) u_rf1 (
      .clK(clk), .rst_N(rst_n),
      .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_ad), .a_port_data_IN(a_di),
      .a_port_data_OUT(dq[0][0]), .a_port_VALID(vq[0][0]),
      .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_ad), .b_port_data_IN(b_di),
      .b_port_data_OUT(dq[0][1]), .b_port_VALID(vq[0][1]),
      .coll_ERR(cerr[0]), .coll_CNT(ccnt[0]));

   dpram_pipe #(.RD_LAT(2), .RDW_MODE(1)) u_wf2 (
      .clK(clk), .rst_N(rst_n),
      .a_port_EN(a_en), .a_port_WR(a_wr), .a_port_BE(a_be), .a_port_ADDR(a_ad), .a_port_data_IN(a_di),
      .a_port_data_OUT(dq[1][0]), .a_port_VALID(vq[1][0]),
      .b_port_EN(b_en), .b_port_WR(b_wr), .b_port_BE(b_be), .b_port_ADDR(b_ad), .b_port_data_IN(b_di),
      .b_port_data_OUT(dq[1][1]), .b_port_VALID(vq[1][1]),
      .coll_ERR(cerr[1]), .coll_CNT(ccnt[1]));

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          chk_data;
   logic [15:0] mem_m [32];
   logic        ev [2][2][4];
   logic [15:0] ew [2][2][4];
   logic [15:0] last [2][2];
   logic        exp_err;
   int          exp_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
      logic [15:0] r;
      r = o;
      for (int k = 0; k < 2; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) begin
            last[k][p] = '0;
            for (int s = 0; s < 4; s++) ev[k][p][s] = 1'b0;
         end
      exp_err = 1'b0;
      exp_cnt = 0;
   endtask

   // instance k has latency k+1; instance 1 is write-first
   task automatic model_step();
      logic [15:0] oa, ob;
      bit          coll;
      int          s;
      cyc++;
      oa = mem_m[a_ad];
      ob = mem_m[b_ad];
      for (int k = 0; k < 2; k++) begin
         s = (cyc + k) % 4;
         if (a_en) begin
            ev[k][0][s] = 1'b1;
            ew[k][0][s] = (a_wr && k == 1) ? merge(oa, a_di, a_be) : oa;
         end
         if (b_en) begin
            ev[k][1][s] = 1'b1;
            ew[k][1][s] = (b_wr && k == 1) ? merge(ob, b_di, b_be) : ob;
         end
      end
      coll = a_en && a_wr && b_en && b_wr && a_ad == b_ad;
      if (coll) mem_m[a_ad] = merge(merge(oa, b_di, b_be), a_di, a_be);
      else begin
         if (a_en && a_wr) mem_m[a_ad] = merge(oa, a_di, a_be);
         if (b_en && b_wr) mem_m[b_ad] = merge(ob, b_di, b_be);
      end
      exp_err = coll && (a_be & b_be) != 2'b00;
      if (exp_err && exp_cnt < 255) exp_cnt++;
   endtask

   task automatic check_all();
      int s;
      s = cyc % 4;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (ev[k][p][s]) last[k][p] = ew[k][p][s];
            check($sformatf("valid_i%0d_p%0d", k, p), 32'(vq[k][p]), 32'(ev[k][p][s]));
            if (chk_data) check($sformatf("data_i%0d_p%0d", k, p), 32'(dq[k][p]), 32'(last[k][p]));
            ev[k][p][s] = 1'b0;
         end
         check($sformatf("coll_err_i%0d", k), 32'(cerr[k]), 32'(exp_err));
         check($sformatf("coll_cnt_i%0d", k), 32'(ccnt[k]), 32'(exp_cnt));
      end
   endtask

   task automatic step(input logic ae, input logic aw, input logic [1:0] abe, input logic [4:0] aad, input logic [15:0] ad,
                       input logic be_, input logic bw, input logic [1:0] bbe, input logic [4:0] bad, input logic [15:0] bd);
      a_en = ae; a_wr = aw; a_be = abe; a_ad = aad; a_di = ad;
      b_en = be_; b_wr = bw; b_be = bbe; b_ad = bad; b_di = bd;
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 2'b00, 5'd0, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
   endtask

   initial begin
      logic [4:0] r;
      rst_n = 1'b0;
      chk_data = 1'b1;
      model_reset();
      idle();
      idle();
      for (int k = 0; k < 2; k++) begin
         check("rst_valid_a", 32'(vq[k][0]), 32'(0));
         check("rst_data_b", 32'(dq[k][1]), 32'(0));
         check("rst_cnt", 32'(ccnt[k]), 32'(0));
      end
      rst_n = 1'b1;
      // prefill every word; read-first returns unwritten contents here, so data is not compared
      chk_data = 1'b0;
      for (int i = 0; i < 32; i++) step(1, 1, 2'b11, 5'(i), 16'($urandom), 0, 0, 2'b00, 5'd0, 16'h0);
      rst_n = 1'b0;
      model_reset();
      idle();
      rst_n = 1'b1;
      chk_data = 1'b1;
      idle();
      // basic latency
      step(1, 1, 2'b11, 5'd3, 16'hBEEF, 0, 0, 2'b00, 5'd0, 16'h0);
      step(0, 0, 2'b00, 5'd0, 16'h0, 1, 0, 2'b00, 5'd3, 16'h0);
      check("beef_lat1", 32'(dq[0][1]), 32'(16'hBEEF));
      idle();
      check("beef_lat2", 32'(dq[1][1]), 32'(16'hBEEF));
      // throughput
      for (int i = 0; i < 8; i++) step(1, 1, 2'b11, 5'(i), 16'(16'h1000 + i), 0, 0, 2'b00, 5'd0, 16'h0);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 2'b00, 5'(i), 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
         check("thru_lat1", 32'(dq[0][0]), 32'(16'h1000 + i));
         if (i > 0) check("thru_lat2", 32'(dq[1][0]), 32'(16'h1000 + i - 1));
      end
      idle();
      check("thru_lat2_last", 32'(dq[1][0]), 32'(16'h1007));
      // byte enables
      step(1, 1, 2'b11, 5'd5, 16'h1234, 0, 0, 2'b00, 5'd0, 16'h0);
      step(1, 1, 2'b10, 5'd5, 16'hABCD, 0, 0, 2'b00, 5'd0, 16'h0);
      step(1, 0, 2'b00, 5'd5, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
      check("be_merge", 32'(dq[0][0]), 32'(16'hAB34));
      // read-during-write modes
      step(1, 1, 2'b11, 5'd7, 16'h1111, 0, 0, 2'b00, 5'd0, 16'h0);
      step(1, 1, 2'b11, 5'd7, 16'h2222, 1, 0, 2'b00, 5'd7, 16'h0);
      check("rdw_rf_a", 32'(dq[0][0]), 32'(16'h1111));
      check("rdw_rf_b", 32'(dq[0][1]), 32'(16'h1111));
      idle();
      check("rdw_wf_a", 32'(dq[1][0]), 32'(16'h2222));
      check("rdw_wf_b", 32'(dq[1][1]), 32'(16'h1111));
      // collisions
      step(1, 1, 2'b11, 5'd9, 16'hAAAA, 1, 1, 2'b01, 5'd9, 16'h5555);
      check("coll_err", 32'(cerr[0]), 32'(1));
      check("coll_cnt1", 32'(ccnt[0]), 32'(1));
      step(1, 0, 2'b00, 5'd9, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
      check("coll_word", 32'(dq[0][0]), 32'(16'hAAAA));
      step(1, 1, 2'b10, 5'd9, 16'hAAAA, 1, 1, 2'b01, 5'd9, 16'h5555);
      check("disjoint_err", 32'(cerr[0]), 32'(0));
      check("disjoint_cnt", 32'(ccnt[1]), 32'(1));
      step(1, 0, 2'b00, 5'd9, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
      check("disjoint_word", 32'(dq[0][0]), 32'(16'hAA55));
      // random traffic concentrated on a few addresses
      for (int i = 0; i < 400; i++) begin
         logic [4:0] aa, ba;
         aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         ba = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         step(1'($urandom), 1'($urandom), 2'($urandom), aa, 16'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), ba, 16'($urandom));
      end
      // saturation
      for (int i = 0; i < 300; i++) begin
         r = 5'($urandom);
         step(1, 1, 2'b11, r, 16'($urandom), 1, 1, 2'b11, r, 16'($urandom));
      end
      check("sat_cnt0", 32'(ccnt[0]), 32'(255));
      check("sat_cnt1", 32'(ccnt[1]), 32'(255));
      // reset with reads in flight
      a_en = 1'b1; a_wr = 1'b0; a_ad = 5'd3;
      b_en = 1'b1; b_wr = 1'b0; b_ad = 5'd5;
      @(posedge clk);
      model_step();
      #1;
      rst_n = 1'b0;
      model_reset();
      a_en = 1'b0;
      b_en = 1'b0;
      #1;
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < 2; p++) begin
            check("midrst_valid", 32'(vq[k][p]), 32'(0));
            check("midrst_data", 32'(dq[k][p]), 32'(0));
         end
      check("midrst_cnt", 32'(ccnt[1]), 32'(0));
      @(negedge clk);
      check_all();
      idle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) idle();
      step(1, 0, 2'b00, 5'd3, 16'h0, 0, 0, 2'b00, 5'd0, 16'h0);
      idle();
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
